rop3_blit_seq: RTL and testbench

- Upstream sequencer for the 3-operand raster-op core (rop3_smart / rop3_lut256: clk, P, S, D, Mode, Result; parameter N).
- Accepts a blit command (mode, pattern, pixel count) and streams paired S/D pixels from a source into the core, one per cycle.
- Collects core Result values into an output buffer and presents them downstream with valid/ready and a last flag.
- Credit-based issue guarantees no Result is lost under backpressure.

---
 rtl/rop3_blit_if.sv | 49 ++++
 rtl/rop3_blit_seq.sv | 144 ++++++++++++++
 tb/tb_rop3_blit_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rop3_blit_if.sv
// Command, source, core and result-stream signals of the ROP3 blit sequencer.
// slave is the sequencer's view; master is the command, source, core and sink side.
interface rop3_blit_if #(
    parameter int N     = 5,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_mode;
    logic [N-1:0]     cmd_pat;
    logic [LEN_W-1:0] cmd_len;

    logic             src_valid;
    logic             src_ready;
    logic [N-1:0]     src_s;
    logic [N-1:0]     src_d;

    logic [N-1:0]     rop_P;
    logic [N-1:0]     rop_S;
    logic [N-1:0]     rop_D;
    logic [7:0]       rop_Mode;
    logic [N-1:0]     rop_Result;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_last;

    logic             busy;
    logic             done;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_pat, cmd_len,
        input  src_valid, src_s, src_d,
        input  rop_Result, out_ready,
        output cmd_ready, src_ready,
        output rop_P, rop_S, rop_D, rop_Mode,
        output out_valid, out_data, out_last, busy, done
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_pat, cmd_len,
        output src_valid, src_s, src_d,
        output rop_Result, out_ready,
        input  cmd_ready, src_ready,
        input  rop_P, rop_S, rop_D, rop_Mode,
        input  out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/rop3_blit_seq.sv
// Blit sequencer: feeds S/D pixel pairs into a ROP3 core and buffers its results,
// issuing only while buffer space is reserved for every result in flight.
module rop3_blit_seq #(
    parameter int N          = 5,
    parameter int LEN_W      = 8,
    parameter int ROP_LAT    = 1,
    parameter int OBUF_DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    rop3_blit_if.slave bus
);
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(OBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [LEN_W-1:0] rem_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    infl_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [N-1:0]     buf_data [OBUF_DEPTH];
    logic             buf_last [OBUF_DEPTH];
    logic [ROP_LAT:0] pipe_v_reg;
    logic [ROP_LAT:0] pipe_l_reg;
    logic             done_reg;

    logic cmd_fire, issue, push, pop, credit_ok;

    // Buffer entries plus results still inside the core must never exceed the buffer.
    assign credit_ok = ({1'b0, count_reg} + {1'b0, infl_reg}) < DEPTH_C;
    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign issue     = bus.src_valid && bus.src_ready;
    assign push      = pipe_v_reg[ROP_LAT];
    assign pop       = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_fire && bus.cmd_len != '0) state_next = RUN;
            RUN:     if (issue && rem_reg == LEN_W'(1)) state_next = DRAIN;
            DRAIN:   if (pop && bus.out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_reg == IDLE);
        bus.src_ready = (state_reg == RUN) && credit_ok;
        bus.busy      = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rop_P    <= '0;
            bus.rop_S    <= '0;
            bus.rop_D    <= '0;
            bus.rop_Mode <= '0;
            rem_reg      <= '0;
            count_reg    <= '0;
            infl_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= (cmd_fire && bus.cmd_len == '0)
                      || (state_reg == DRAIN && pop && bus.out_last);
            if (cmd_fire) begin
                bus.rop_Mode <= bus.cmd_mode;
                bus.rop_P    <= bus.cmd_pat;
                rem_reg      <= bus.cmd_len;
            end
            if (issue) begin
                bus.rop_S <= bus.src_s;
                bus.rop_D <= bus.src_d;
                rem_reg   <= rem_reg - 1'b1;
            end
            if (issue && !push) begin
                infl_reg <= infl_reg + 1'b1;
            end else if (!issue && push) begin
                infl_reg <= infl_reg - 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && pop) begin
                count_reg <= count_reg - 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(OBUF_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(OBUF_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
        end
    end

    // Token pipe mirrors the core latency so each Result is captured when it is valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v_reg[0] <= 1'b0;
            pipe_l_reg[0] <= 1'b0;
        end else begin
            pipe_v_reg[0] <= issue;
            pipe_l_reg[0] <= (rem_reg == LEN_W'(1));
        end
    end

    generate
        for (genvar gi = 1; gi <= ROP_LAT; gi++) begin : g_pipe
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pipe_v_reg[gi] <= 1'b0;
                    pipe_l_reg[gi] <= 1'b0;
                end else begin
                    pipe_v_reg[gi] <= pipe_v_reg[gi-1];
                    pipe_l_reg[gi] <= pipe_l_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr_reg] <= bus.rop_Result;
            buf_last[wr_ptr_reg] <= pipe_l_reg[ROP_LAT];
        end
    end

    assign bus.out_valid = (count_reg != '0);
    assign bus.out_data  = buf_data[rd_ptr_reg];
    assign bus.out_last  = buf_last[rd_ptr_reg];
    assign bus.done      = done_reg;
endmodule

// File: tb/tb_rop3_blit_seq.sv
// Bench for rop3_blit_seq: behavioural ROP3 core model, source driver and a
// scoreboard of {last, data} expectations checked on every output pop.
module tb_rop3_blit_seq;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   hs_cnt = 0;
    int   pop_cnt = 0;
    int   done_cnt = 0;
    logic arm_lat = 0, seen_hs = 0, seen_ov = 0;
    int   hs_edge = 0, ov_edge = 0;
    logic [4:0] s_q [$];
    logic [4:0] d_q [$];
    logic [5:0] exp_q [$];
    logic [5:0] exp_e;

    rop3_blit_if #(.N(5), .LEN_W(8)) bus ();

    rop3_blit_seq #(.N(5), .LEN_W(8), .ROP_LAT(1), .OBUF_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] rop3(input logic [7:0] m, input logic [4:0] p,
                                        input logic [4:0] s, input logic [4:0] d);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = m[{p[i], s[i], d[i]}];
        return r;
    endfunction

    // One-cycle core: samples the registered operands, Result valid after the next edge.
    always @(posedge clk) bus.rop_Result <= rop3(bus.rop_Mode, bus.rop_P, bus.rop_S, bus.rop_D);

    always @(negedge clk) begin
        if (rst_n && bus.done) done_cnt++;
        if (arm_lat) begin
            if (!seen_hs && bus.src_valid && bus.src_ready) begin
                hs_edge = cyc + 1;
                seen_hs = 1;
            end
            if (!seen_ov && bus.out_valid) begin
                ov_edge = cyc;
                seen_ov = 1;
            end
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            pop_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_pop: got data=%h last=%b, required no output", bus.out_data, bus.out_last);
            end else begin
                exp_e = exp_q.pop_front();
                if ({bus.out_last, bus.out_data} !== exp_e) begin
                    bad++;
                    $display("FAIL out_pop: got data=%h last=%b, required data=%h last=%b",
                             bus.out_data, bus.out_last, exp_e[4:0], exp_e[5]);
                end else begin
                    $display("pop data=%h last=%b ok", bus.out_data, bus.out_last);
                end
            end
        end
    end

    task automatic push_px(input logic [4:0] s, input logic [4:0] d, input logic [4:0] e, input logic last);
        s_q.push_back(s);
        d_q.push_back(d);
        exp_q.push_back({last, e});
    endtask

    task automatic send_cmd(input logic [7:0] m, input logic [4:0] p, input logic [7:0] len, input string name);
        int g = 0;
        logic acc = 0;
        bus.cmd_valid = 1; bus.cmd_mode = m; bus.cmd_pat = p; bus.cmd_len = len;
        while (!acc && g < 200) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk); #1;
            g++;
        end
        bus.cmd_valid = 0;
        total++;
        if (acc !== 1'b1) begin
            bad++;
            $display("FAIL %s cmd_accept: got no handshake in %0d cycles, required accept", name, g);
        end else begin
            $display("cmd %s mode=%h pat=%h len=%0d accepted", name, m, p, len);
        end
    endtask

    task automatic drive_src(input int n, input string name);
        int sent = 0;
        int g = 0;
        logic [4:0] s, d;
        while (sent < n && g < 400) begin
            bus.src_valid = 1; bus.src_s = s_q[0]; bus.src_d = d_q[0];
            @(negedge clk);
            if (bus.src_ready) begin
                s = s_q.pop_front();
                d = d_q.pop_front();
                sent++;
                hs_cnt++;
            end
            @(posedge clk); #1;
            g++;
        end
        bus.src_valid = 0;
        total++;
        if (sent != n) begin
            bad++;
            $display("FAIL %s src_issue: got %0d handshakes, required %0d", name, sent, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || bus.busy) && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s drain: got %0d results missing, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.cmd_valid = 0; bus.cmd_mode = 0; bus.cmd_pat = 0; bus.cmd_len = 0;
        bus.src_valid = 0; bus.src_s = 0; bus.src_d = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.src_ready, bus.busy, bus.done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got ov/sr/busy/done=%b, required 0000",
                     {bus.out_valid, bus.src_ready, bus.busy, bus.done});
        end
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_cmd_ready: got %b, required 1", bus.cmd_ready);
        end
        total++;
        if ({bus.rop_P, bus.rop_S, bus.rop_D, bus.rop_Mode} !== 23'd0) begin
            bad++;
            $display("FAIL reset_rop: got P=%h S=%h D=%h M=%h, required all 0",
                     bus.rop_P, bus.rop_S, bus.rop_D, bus.rop_Mode);
        end
        @(posedge clk); #1;
        $display("reset checked");
    endtask

    task automatic test_basic();
        int d0;
        bus.out_ready = 1;
        for (int i = 1; i <= 4; i++) push_px(5'(i), 5'd0, 5'(i), i == 4);
        d0 = done_cnt;
        seen_hs = 0; seen_ov = 0; arm_lat = 1;
        send_cmd(8'hCC, 5'd0, 8'd4, "basic");
        drive_src(4, "basic");
        wait_idle("basic");
        arm_lat = 0;
        total++;
        if (!seen_hs || !seen_ov || (ov_edge - hs_edge) != 2) begin
            bad++;
            $display("FAIL basic_latency: got %0d edges (hs=%b ov=%b), required 2",
                     ov_edge - hs_edge, seen_hs, seen_ov);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_modes();
        logic [4:0] p;
        for (int i = 0; i < 3; i++) push_px(5'h15, 5'h0F, 5'h1A, i == 2);
        send_cmd(8'h66, 5'd0, 8'd3, "xor");
        drive_src(3, "xor");
        wait_idle("xor");
        for (int i = 0; i < 5; i++) push_px(5'($urandom), 5'($urandom), 5'h1F, i == 4);
        send_cmd(8'hF0, 5'h1F, 8'd5, "pat");
        drive_src(5, "pat");
        wait_idle("pat");
        p = 5'($urandom);
        for (int i = 0; i < 4; i++) push_px(5'($urandom), 5'($urandom), 5'h00, i == 3);
        send_cmd(8'h00, p, 8'd4, "zero");
        drive_src(4, "zero");
        wait_idle("zero");
    endtask

    task automatic test_backpressure();
        int h0, p0;
        bus.out_ready = 0;
        for (int i = 0; i < 8; i++) push_px(5'(i + 3), 5'($urandom), 5'(i + 3), i == 7);
        h0 = hs_cnt;
        p0 = pop_cnt;
        send_cmd(8'hCC, 5'd0, 8'd8, "bp");
        fork
            drive_src(8, "bp");
            begin
                repeat (20) @(negedge clk);
                total++;
                if (hs_cnt - h0 != 4) begin
                    bad++;
                    $display("FAIL bp_credit: got %0d handshakes, required 4", hs_cnt - h0);
                end
                total++;
                if (bus.src_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_src_ready: got %b, required 0", bus.src_ready);
                end
                @(posedge clk); #1;
                bus.out_ready = 1;
            end
        join
        wait_idle("bp");
        total++;
        if (pop_cnt - p0 != 8) begin
            bad++;
            $display("FAIL bp_count: got %0d results, required 8", pop_cnt - p0);
        end
    endtask

    task automatic test_empty();
        int bad_cyc = 0;
        send_cmd(8'h5A, 5'h13, 8'd0, "empty");
        @(negedge clk);
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL empty_done: got %b, required 1", bus.done);
        end
        total++;
        if ({bus.rop_Mode, bus.rop_P} !== {8'h5A, 5'h13}) begin
            bad++;
            $display("FAIL empty_latch: got mode=%h pat=%h, required 5a/13", bus.rop_Mode, bus.rop_P);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid || bus.src_ready || bus.busy || bus.done) bad_cyc++;
        end
        total++;
        if (bad_cyc != 0) begin
            bad++;
            $display("FAIL empty_quiet: got %0d active cycles, required 0", bad_cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int p0;
        for (int i = 0; i < 6; i++) s_q.push_back(5'(i + 10));
        for (int i = 0; i < 6; i++) d_q.push_back(5'd0);
        send_cmd(8'hCC, 5'd0, 8'd6, "rmid");
        drive_src(2, "rmid");
        s_q.delete();
        d_q.delete();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.busy, bus.cmd_ready} !== 3'b001) begin
            bad++;
            $display("FAIL rmid_state: got ov/busy/cr=%b, required 001",
                     {bus.out_valid, bus.busy, bus.cmd_ready});
        end
        @(posedge clk); #1;
        p0 = pop_cnt;
        push_px(5'd7, 5'd0, 5'd7, 1'b0);
        push_px(5'd9, 5'd0, 5'd9, 1'b1);
        send_cmd(8'hCC, 5'd0, 8'd2, "rfresh");
        drive_src(2, "rfresh");
        wait_idle("rfresh");
        total++;
        if (pop_cnt - p0 != 2) begin
            bad++;
            $display("FAIL rmid_count: got %0d results, required 2", pop_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        int g = 0;
        int d0;
        logic acc = 0, acc_b = 0, done_at = 0;
        for (int i = 1; i <= 3; i++) push_px(5'(i), 5'd0, 5'(i), i == 3);
        push_px(5'h15, 5'h0F, 5'h1A, 1'b0);
        push_px(5'h15, 5'h0F, 5'h1A, 1'b1);
        d0 = done_cnt;
        bus.cmd_valid = 1; bus.cmd_mode = 8'hCC; bus.cmd_pat = 5'd0; bus.cmd_len = 8'd3;
        while (!acc && g < 200) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk); #1;
            g++;
        end
        bus.cmd_mode = 8'h66; bus.cmd_len = 8'd2;
        fork
            drive_src(5, "b2b");
            begin
                g = 0;
                while (!acc_b && g < 300) begin
                    @(negedge clk);
                    if (bus.cmd_ready) begin
                        acc_b = 1;
                        done_at = bus.done;
                    end
                    @(posedge clk); #1;
                    g++;
                end
                bus.cmd_valid = 0;
            end
        join
        wait_idle("b2b");
        total++;
        if ({acc, acc_b, done_at} !== 3'b111) begin
            bad++;
            $display("FAIL b2b_accept: got accA/accB/done_at=%b, required 111", {acc, acc_b, done_at});
        end
        total++;
        if (done_cnt - d0 != 2) begin
            bad++;
            $display("FAIL b2b_done: got %0d pulses, required 2", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_backpressure();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
